mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide execute-stage unit, directly downstream of the register file.
- Consumes the two register read operands (rs → operand_a, rt → operand_b) and computes MIPS MULT/MULTU/DIV/DIVU into architectural HI/LO registers.
- Also services MTHI/MTLO writes. HI/LO are read by the writeback path for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; accepted only when busy=0
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- operand_a  input  WIDTH  rs value (multiplicand/dividend); sampled with start
- operand_b  input  WIDTH  rt value (multiplier/divisor); sampled with start
- flush  input  1  synchronous cancel of an in-flight operation
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- mt_data  input  WIDTH  data for MTHI/MTLO
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse when HI/LO are updated with a result
- div_zero  output  1  one-cycle pulse coincident with done when a DIV/DIVU had divisor 0

Behaviour:
- Reset (reset_n=0, asynchronous): hi=0, lo=0, busy=0, done=0, div_zero=0, FSM=IDLE, counter=0.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - On an edge with start=1: latch op, sign flags, and magnitudes.
  - Signed ops use |operand|; unsigned ops use raw values.
  - busy←1, counter←0, go to CALC.
- CALC, one edge per iteration, exactly WIDTH edges:
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - After the WIDTH-th iteration, go to FIX.
- FIX, one edge:
  - Apply sign correction.
  - Write hi/lo, done←1, div_zero←(divide and divisor==0), busy←0, go to IDLE.
- Latency:
  - Start edge = edge 0; CALC = edges 1..WIDTH; FIX = edge WIDTH+1.
  - hi/lo/done valid after edge WIDTH+1 (33 for default). busy high for exactly WIDTH+1 cycles.
- done and div_zero are single-cycle pulses, cleared on the following edge.
- Arithmetic rules:
  - MULT/MULTU: {hi,lo} = 2*WIDTH-bit product. Signed product negated (two's complement, full 64 bits) when sign_a xor sign_b.
  - DIV/DIVU: lo = quotient, hi = remainder. Signed: quotient negated when sign_a xor sign_b; remainder takes sign of dividend (truncation toward zero).
  - Divide by zero (either signedness): lo = all ones, hi = operand_a as sampled; normal latency, div_zero pulses.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0, no flag.
- start while busy=1: ignored; no queuing.
- flush=1:
  - While busy: FSM→IDLE and busy←0 on that edge. hi/lo unchanged, no done.
  - While idle: no effect.
  - flush and start on the same edge in IDLE: flush wins; start dropped.
- hi_we/lo_we:
  - While idle: hi/lo ← mt_data on the edge.
  - While busy: ignored.
  - Same edge as an accepted start: write occurs; the later result overwrites it.
- Operand inputs may change freely after the start edge; only sampled values are used.
- Reset asserted mid-operation: immediate return to reset values, no done.

Test Plan:
- Reset: hold reset_n=0 with start=1 → hi=lo=0, busy=done=0. Release, idle 5 cycles → unchanged.
- MULT a=0xFFFFFFFD (-3), b=7 → busy for 33 cycles; done pulse at edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB. Repeat as MULTU → hi=0x00000006, lo=0xFFFFFFEB.
- DIV a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234, div_zero and done pulse together for one cycle.
- Mid-operation events:
  - Start MULTU 5×5; at edge 10 assert start with new operands → ignored; result hi=0, lo=25.
  - Next op: assert flush at edge 10 → busy drops, no done, hi/lo retain 0/25.
  - Assert reset_n=0 mid-op → all outputs to zero immediately.
- MTHI/MTLO:
  - Idle: hi_we with mt_data=0xCAFEBABE → hi updates next edge. lo_we with mt_data=0x12345678 → lo updates next edge.
  - During busy: lo_we ignored; final lo equals the computed result.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Operand, control and HI/LO result bundle between the register-file stage and the
// iterative multiply/divide unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] mt_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, operand_a, operand_b, flush, hi_we, lo_we, mt_data,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b, flush, hi_we, lo_we, mt_data,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers:
// one iteration per clock over magnitudes, sign fix-up in a final cycle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic            clock,
  input logic            reset_n,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [WIDTH-1:0]     operand_reg, operand_next;
  logic [WIDTH-1:0]     dividend_reg, dividend_next;
  logic                 is_div_reg, is_div_next;
  logic                 neg_q_reg, neg_q_next;
  logic                 neg_r_reg, neg_r_next;
  logic [WIDTH-1:0]     hi_reg, hi_next;
  logic [WIDTH-1:0]     lo_reg, lo_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 div_zero_reg, div_zero_next;

  // Operand conditioning at the start edge: signed ops work on magnitudes.
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign sign_a = ~bus.op[0] & bus.operand_a[WIDTH-1];
  assign sign_b = ~bus.op[0] & bus.operand_b[WIDTH-1];
  assign mag_a  = sign_a ? -bus.operand_a : bus.operand_a;
  assign mag_b  = sign_b ? -bus.operand_b : bus.operand_b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;

  assign mul_sum  = acc_reg[0] ? ({1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, operand_reg})
                               : {1'b0, acc_reg[2*WIDTH-1:WIDTH]};
  assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}, shifted left.
  logic [WIDTH:0]     div_rem, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_step;

  assign div_rem  = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_diff = div_rem - {1'b0, operand_reg};
  assign div_ge   = div_rem >= {1'b0, operand_reg};
  assign div_step = {(div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0]),
                     acc_reg[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] product_fixed;
  logic [WIDTH-1:0]   quot_fixed, rem_fixed;
  logic               div_by_zero;

  assign product_fixed = neg_q_reg ? -acc_reg : acc_reg;
  assign quot_fixed    = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem_fixed     = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
  assign div_by_zero   = (operand_reg == '0);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    acc_next      = acc_reg;
    operand_next  = operand_reg;
    dividend_next = dividend_reg;
    is_div_next   = is_div_reg;
    neg_q_next    = neg_q_reg;
    neg_r_next    = neg_r_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    div_zero_next = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        if (bus.hi_we) hi_next = bus.mt_data;
        if (bus.lo_we) lo_next = bus.mt_data;
        if (bus.start && !bus.flush) begin
          state_next    = S_CALC;
          busy_next     = 1'b1;
          cnt_next      = '0;
          is_div_next   = bus.op[1];
          neg_q_next    = sign_a ^ sign_b;
          neg_r_next    = sign_a;
          dividend_next = bus.operand_a;
          if (bus.op[1]) begin
            operand_next = mag_b;
            acc_next     = {{WIDTH{1'b0}}, mag_a};
          end else begin
            operand_next = mag_a;
            acc_next     = {{WIDTH{1'b0}}, mag_b};
          end
        end
      end

      S_CALC: begin
        if (bus.flush) begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
        end else begin
          acc_next = is_div_reg ? div_step : mul_step;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST_ITER) state_next = S_FIX;
        end
      end

      S_FIX: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
        if (!bus.flush) begin
          done_next = 1'b1;
          if (!is_div_reg) begin
            {hi_next, lo_next} = product_fixed;
          end else if (div_by_zero) begin
            hi_next       = dividend_reg;
            lo_next       = '1;
            div_zero_next = 1'b1;
          end else begin
            hi_next = rem_fixed;
            lo_next = quot_fixed;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      operand_reg  <= '0;
      dividend_reg <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      acc_reg      <= acc_next;
      operand_reg  <= operand_next;
      dividend_reg <= dividend_next;
      is_div_reg   <= is_div_next;
      neg_q_reg    <= neg_q_next;
      neg_r_reg    <= neg_r_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      div_zero_reg <= div_zero_next;
    end
  end

  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.div_zero = div_zero_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO come from plain 64-bit arithmetic,
// a monitor pops and compares on every done pulse.
module tb_mult_div_unit;

  localparam int WIDTH = 32;

  logic clock;
  logic reset_n;

  mult_div_unit_if #(.WIDTH(WIDTH)) bus_if ();

  mult_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [64:0] exp_q[$];  // {div_zero, hi, lo}
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Reference arithmetic straight from the MIPS definitions.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ez = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin p = 64'(sa * sb); {eh, el} = p; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; {eh, el} = p; end
      default: begin
        if (b == 32'd0) begin
          el = 32'hFFFF_FFFF;
          eh = a;
          ez = 1'b1;
        end else if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          el = q[31:0];
          eh = r[31:0];
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n && bus_if.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(bus_if.done), 64'd0);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        check("hi", 64'(bus_if.hi), 64'(e[63:32]));
        check("lo", 64'(bus_if.lo), 64'(e[31:0]));
        check("div_zero", 64'(bus_if.div_zero), 64'(e[64]));
      end
    end
  end

  // ev_kind: 0 none, 1 second start at edge 10, 2 lo_we at edge 10
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int ev_kind);
    logic [31:0] eh, el;
    logic        ez;
    int          k, busy_cnt;
    bit          seen;
    model(o, a, b, eh, el, ez);
    @(negedge clock);
    bus_if.start     = 1'b1;
    bus_if.op        = o;
    bus_if.operand_a = a;
    bus_if.operand_b = b;
    exp_q.push_back({ez, eh, el});
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b", o, a, b, eh, el, ez);
    k = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      @(negedge clock);
      k++;
      if (k == 1) begin
        bus_if.start     = 1'b0;
        bus_if.op        = 2'($urandom);
        bus_if.operand_a = $urandom;
        bus_if.operand_b = $urandom;
      end
      if (k == 10 && ev_kind == 1) begin
        bus_if.start     = 1'b1;
        bus_if.op        = 2'b00;
        bus_if.operand_a = 32'd3;
        bus_if.operand_b = 32'd9;
      end
      if (k == 10 && ev_kind == 2) begin
        bus_if.lo_we   = 1'b1;
        bus_if.mt_data = 32'hDEAD_BEEF;
      end
      if (k == 11) begin
        bus_if.start = 1'b0;
        bus_if.lo_we = 1'b0;
      end
      if (bus_if.busy) busy_cnt++;
      if (bus_if.done) seen = 1'b1;
    end
    if (!seen) begin
      check("done_timeout", 64'(seen), 64'd1);
    end else begin
      check("latency", 64'(k - 1), 64'(WIDTH + 1));
      check("busy_cycles", 64'(busy_cnt), 64'(WIDTH + 1));
      @(negedge clock);
      check("done_pulse", 64'(bus_if.done), 64'd0);
      check("div_zero_pulse", 64'(bus_if.div_zero), 64'd0);
    end
    model_hi = eh;
    model_lo = el;
  endtask

  // kind: 0 flush at edge 10, 1 reset at edge 10
  task automatic abort_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int kind);
    @(negedge clock);
    bus_if.start     = 1'b1;
    bus_if.op        = o;
    bus_if.operand_a = a;
    bus_if.operand_b = b;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 1) bus_if.start = 1'b0;
    end
    if (kind == 0) begin
      bus_if.flush = 1'b1;
      @(negedge clock);
      bus_if.flush = 1'b0;
      check("flush_busy", 64'(bus_if.busy), 64'd0);
      check("flush_done", 64'(bus_if.done), 64'd0);
    end else begin
      reset_n = 1'b0;
      #1;
      model_hi = '0;
      model_lo = '0;
      check("rst_hi", 64'(bus_if.hi), 64'd0);
      check("rst_lo", 64'(bus_if.lo), 64'd0);
      check("rst_busy", 64'(bus_if.busy), 64'd0);
      check("rst_done", 64'(bus_if.done), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
    end
    repeat (40) @(negedge clock);
    check("abort_hi", 64'(bus_if.hi), 64'(model_hi));
    check("abort_lo", 64'(bus_if.lo), 64'(model_lo));
  endtask

  task automatic mt_write(input logic we_hi, input logic [31:0] data);
    @(negedge clock);
    bus_if.hi_we   = we_hi;
    bus_if.lo_we   = ~we_hi;
    bus_if.mt_data = data;
    @(negedge clock);
    bus_if.hi_we = 1'b0;
    bus_if.lo_we = 1'b0;
    if (we_hi) model_hi = data;
    else       model_lo = data;
    check("mt_hi", 64'(bus_if.hi), 64'(model_hi));
    check("mt_lo", 64'(bus_if.lo), 64'(model_lo));
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset_n          = 1'b0;
    bus_if.start     = 1'b1;
    bus_if.op        = 2'b01;
    bus_if.operand_a = 32'd5;
    bus_if.operand_b = 32'd5;
    bus_if.flush     = 1'b0;
    bus_if.hi_we     = 1'b0;
    bus_if.lo_we     = 1'b0;
    bus_if.mt_data   = '0;
    repeat (3) @(negedge clock);
    check("reset_hi", 64'(bus_if.hi), 64'd0);
    check("reset_lo", 64'(bus_if.lo), 64'd0);
    check("reset_busy", 64'(bus_if.busy), 64'd0);
    check("reset_done", 64'(bus_if.done), 64'd0);
    bus_if.start = 1'b0;
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_hi", 64'(bus_if.hi), 64'd0);
    check("idle_lo", 64'(bus_if.lo), 64'd0);
    check("idle_busy", 64'(bus_if.busy), 64'd0);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'b11, 32'd100, 32'd7, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b11, 32'h0000_1234, 32'd0, 0);
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, 0);
    run_op(2'b01, 32'd5, 32'd5, 1);
    abort_op(2'b00, 32'd123, 32'd456, 0);
    mt_write(1'b1, 32'hCAFE_BABE);
    mt_write(1'b0, 32'h1234_5678);
    run_op(2'b11, 32'd1000, 32'd33, 2);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = $urandom_range(0, 20);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      run_op(2'($urandom_range(0, 3)), ra, rb, 0);
    end

    abort_op(2'b10, 32'd77, 32'd5, 1);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
